button_conditioner: RTL and testbench



---
 rtl/button_pkg.sv | 23 ++
 rtl/button_channel.sv | 134 +++++++++++++
 rtl/button_conditioner.sv | 52 +++++
 tb/tb_button_conditioner.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the push-button front end.
package button_pkg;

  // Auto-repeat controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Bits needed to hold values 0..max_val (never less than one bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Larger of two unsigned values, used to size the shared repeat counter
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, stability filter, press/release edge
// pulses and the typematic auto-repeat controller.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY  = 0,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inp,
  output logic level,
  output logic outp,
  output logic release_pulse
);

  localparam int unsigned CW       = cnt_width(STABLE_CYCLES);
  localparam int unsigned RW       = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam bit          RPT_EN   = (REPEAT_DELAY > 0);
  localparam int unsigned CNT_LAST = (STABLE_CYCLES > 0) ? STABLE_CYCLES - 1 : 0;
  localparam int unsigned DLY_LAST = RPT_EN ? REPEAT_DELAY - 1 : 0;
  localparam int unsigned PER_LAST = (REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt;
  logic                   accept_c;
  logic                   press_c;
  logic                   rel_c;

  rpt_state_e             state;
  rpt_state_e             state_nxt;
  logic [RW-1:0]          rcnt;
  logic [RW-1:0]          rcnt_nxt;
  logic                   rpt_fire_c;

  // Metastability synchroniser; the oldest stage feeds the filter
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], inp};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // A differing sample is accepted once it has persisted STABLE_CYCLES cycles
  assign accept_c = (sync != level) && (cnt == CW'(CNT_LAST));
  assign press_c  = accept_c && sync;
  assign rel_c    = accept_c && !sync;

  // Stability counter and debounced level
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync == level) begin
      cnt   <= '0;
    end else if (accept_c) begin
      level <= sync;
      cnt   <= '0;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

  // Repeat controller state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  // Repeat controller next state; a release on a due edge suppresses the repeat
  always_comb begin
    state_nxt  = state;
    rcnt_nxt   = rcnt;
    rpt_fire_c = 1'b0;
    case (state)
      IDLE: begin
        rcnt_nxt = '0;
        if (press_c && RPT_EN) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (rel_c) begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end else if (rcnt == RW'(DLY_LAST)) begin
          rpt_fire_c = 1'b1;
          state_nxt  = REPEAT;
          rcnt_nxt   = '0;
        end else begin
          rcnt_nxt = rcnt + RW'(1);
        end
      end
      REPEAT: begin
        if (rel_c) begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end else if (rcnt == RW'(PER_LAST)) begin
          rpt_fire_c = 1'b1;
          rcnt_nxt   = '0;
        end else begin
          rcnt_nxt = rcnt + RW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        rcnt_nxt  = '0;
      end
    endcase
  end

  // Registered event pulses; press and repeat never overlap a release
  always_ff @(posedge clk) begin
    if (rst) begin
      outp          <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      outp          <= press_c | rpt_fire_c;
      release_pulse <= rel_c;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: N independent debounced channels
// with press, release and optional auto-repeat pulses.
// The release output is named release_pulse because "release" is reserved.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY  = 0,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] inp,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] outp,
  output logic [CHANNELS-1:0] release_pulse
);

  // Reject parameter sets the channel logic cannot implement
  if (CHANNELS < 1) begin : g_chk_channels
    $error("button_conditioner: CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("button_conditioner: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1) begin : g_chk_stable
    $error("button_conditioner: STABLE_CYCLES must be >= 1");
  end
  if ((REPEAT_DELAY > 0) && (REPEAT_PERIOD < 1)) begin : g_chk_period
    $error("button_conditioner: REPEAT_PERIOD must be >= 1 when repeat is enabled");
  end

  // One independent conditioner per button
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    button_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_channel (
      .clk          (clk),
      .rst          (rst),
      .inp          (inp[ch]),
      .level        (level[ch]),
      .outp         (outp[ch]),
      .release_pulse(release_pulse[ch])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: three conditioner configurations share one stimulus
// stream; a window-based reference model predicts each edge's outputs.
module tb_button_conditioner;

  localparam int unsigned CH = 4;
  localparam int NI = 3;

  typedef struct packed {
    int                    edge_no;
    logic [NI-1:0][CH-1:0] level;
    logic [NI-1:0][CH-1:0] outp;
    logic [NI-1:0][CH-1:0] rel;
  } exp_t;

  // Per-instance configuration: sync stages, stable cycles, repeat delay/period
  function automatic int p_sync(input int i);
    return (i == 2) ? 3 : 2;
  endfunction
  function automatic int p_stable(input int i);
    return (i == 2) ? 4 : 16;
  endfunction
  function automatic int p_dly(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 20 : 3);
  endfunction
  function automatic int p_per(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 5 : 2);
  endfunction

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] inp = '0;
  logic [CH-1:0] lvl  [NI];
  logic [CH-1:0] outp [NI];
  logic [CH-1:0] rel  [NI];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(2), .STABLE_CYCLES(16),
    .REPEAT_DELAY(0), .REPEAT_PERIOD(8)
  ) dut0 (
    .clk(clk), .rst(rst), .inp(inp),
    .level(lvl[0]), .outp(outp[0]), .release_pulse(rel[0])
  );

  button_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(2), .STABLE_CYCLES(16),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut1 (
    .clk(clk), .rst(rst), .inp(inp),
    .level(lvl[1]), .outp(outp[1]), .release_pulse(rel[1])
  );

  button_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(3), .STABLE_CYCLES(4),
    .REPEAT_DELAY(3), .REPEAT_PERIOD(2)
  ) dut2 (
    .clk(clk), .rst(rst), .inp(inp),
    .level(lvl[2]), .outp(outp[2]), .release_pulse(rel[2])
  );

  // Reference model state
  exp_t                  sbq [$];
  logic [CH-1:0]         hist [$];
  int                    edge_no  = 0;
  int                    rst_edge = 0;
  logic [NI-1:0][CH-1:0] m_lvl    = '0;
  int                    press_e [NI][CH];

  // Input value seen by the synchroniser at edge k (reset wipes history)
  function automatic logic smp(input int k, input int c);
    if (k < 1 || k <= rst_edge) return 1'b0;
    return hist[k-1][c];
  endfunction

  // Predict outputs after the current edge from the input history
  function automatic void model(input logic r, input logic [CH-1:0] x);
    exp_t e;
    int   sy, st, dl, pe, age;
    logic v, uni;
    hist.push_back(x);
    e = '0;
    e.edge_no = edge_no;
    if (r) begin
      rst_edge = edge_no;
      m_lvl = '0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        sy = p_sync(i); st = p_stable(i); dl = p_dly(i); pe = p_per(i);
        for (int c = 0; c < int'(CH); c++) begin
          v   = smp(edge_no - sy, c);
          uni = 1'b1;
          for (int k = edge_no - sy - st + 1; k <= edge_no - sy; k++)
            if (smp(k, c) != v) uni = 1'b0;
          if (uni && (v != m_lvl[i][c])) begin
            m_lvl[i][c] = v;
            if (v) begin
              e.outp[i][c]  = 1'b1;
              press_e[i][c] = edge_no;
            end else begin
              e.rel[i][c] = 1'b1;
            end
          end else if (m_lvl[i][c] && dl > 0) begin
            age = edge_no - press_e[i][c];
            if (age >= dl && ((age - dl) % pe) == 0) e.outp[i][c] = 1'b1;
          end
        end
      end
    end
    e.level = m_lvl;
    sbq.push_back(e);
  endfunction

  // Drive one cycle of stimulus and record the expected response
  task automatic step(input logic r, input logic [CH-1:0] x);
    @(negedge clk);
    rst = r;
    inp = x;
    @(posedge clk);
    edge_no++;
    model(r, x);
  endtask

  // Monitor: compare DUT outputs with the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int i = 0; i < NI; i++) begin
          checks++;
          if (lvl[i] === e.level[i] && outp[i] === e.outp[i] && rel[i] === e.rel[i])
            passed++;
          else
            $display("FAIL dut%0d edge %0d: level=%b outp=%b release=%b, expected level=%b outp=%b release=%b",
                     i, e.edge_no, lvl[i], outp[i], rel[i], e.level[i], e.outp[i], e.rel[i]);
          checks++;
          if ((outp[i] & rel[i]) === '0) passed++;
          else
            $display("FAIL dut%0d edge %0d exclusive: outp&release=%b, expected 0000",
                     i, e.edge_no, outp[i] & rel[i]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [CH-1:0] x;
    logic [CH-1:0] cur;
    int            run [CH];
    logic          r;

    for (int i = 0; i < NI; i++)
      for (int c = 0; c < int'(CH); c++) press_e[i][c] = 0;

    repeat (3) step(1'b1, '0);

    // ch0 held; ch1 two 15-cycle pulses; ch2 held 40; ch3 released on a repeat edge
    for (int t = 0; t < 80; t++) begin
      x[0] = 1'b1;
      x[1] = (t < 15) || (t >= 16 && t < 31);
      x[2] = (t < 40);
      x[3] = (t < 20);
      step(1'b0, x);
    end
    repeat (30) step(1'b0, '0);

    // Long hold with several repeats; ch3 released on the second repeat edge
    for (int t = 0; t < 60; t++) begin
      x = '0;
      x[2] = 1'b1;
      x[3] = (t < 25);
      step(1'b0, x);
    end
    repeat (30) step(1'b0, '0);

    // Reset while buttons are held, then a fresh press from scratch
    repeat (25) step(1'b0, 4'hF);
    step(1'b1, 4'hF);
    repeat (40) step(1'b0, 4'hF);
    repeat (30) step(1'b0, '0);

    // Random run lengths, including sub-filter glitches and rare resets
    cur = '0;
    for (int c = 0; c < int'(CH); c++) run[c] = 0;
    for (int t = 0; t < 1500; t++) begin
      for (int c = 0; c < int'(CH); c++) begin
        if (run[c] == 0) begin
          cur[c] = ~cur[c];
          run[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                               : int'($urandom_range(10, 45));
        end
        run[c]--;
      end
      r = ($urandom_range(0, 399) == 0);
      step(r, cur);
    end
    repeat (40) step(1'b0, '0);

    repeat (3) @(posedge clk);
    checks++;
    if (sbq.size() == 0) passed++;
    else $display("FAIL drain: %0d predictions left unchecked, expected 0", sbq.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
